// File: rtl/buf_port_arbiter.sv
// -----------------------------------------------------------------------------
// buf_port_arbiter
//
// Shares one single-port buffer RAM between a host (AXI decoder) port and a
// DMA port. Ownership is granted per tenure: the owner issues one access per
// cycle while it holds req, and gives the port up at the end of its burst
// (last), when it drops req, or when it has issued MAX_HOLD accesses while the
// other port is waiting. Ties out of IDLE are broken round-robin.
//
// Read data returns one cycle after issue. The destination port is tagged at
// issue time, so a hand-over in the same cycle never misroutes the data.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   h_req/h_we/h_addr/h_wdata/h_last   host access request
//   h_gnt, h_rvalid, h_rdata           host grant and read return
//   d_*                                DMA equivalents of the host ports
//   mem_en/mem_we/mem_addr/mem_wdata   buffer access strobe and command
//   mem_rdata                          buffer read data (1-cycle latency)
// -----------------------------------------------------------------------------
module buf_port_arbiter #(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic              h_last,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_last,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        OWN_H,
        OWN_D
    } state_t;

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_TOP = CNT_W'(MAX_HOLD - 1);

    state_t            state;
    logic              rr_last;     // port that released last: 1 = DMA, 0 = host
    logic [CNT_W-1:0]  hold_cnt;    // accesses issued in the current tenure
    logic              h_tag;       // host read issued last cycle
    logic              d_tag;       // DMA read issued last cycle
    logic [DATA_W-1:0] h_hold;      // last host read data, shown while idle
    logic [DATA_W-1:0] d_hold;

    // Owner-side view of the request, selected by the current state.
    logic              own_req;
    logic              own_we;
    logic              own_last;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              other_req;
    logic              release_now;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        own_req   = 1'b0;
        own_we    = 1'b0;
        own_last  = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        other_req = 1'b0;
        case (state)
            OWN_H: begin
                own_req   = h_req;
                own_we    = h_we;
                own_last  = h_last;
                own_addr  = h_addr;
                own_wdata = h_wdata;
                other_req = d_req;
            end
            OWN_D: begin
                own_req   = d_req;
                own_we    = d_we;
                own_last  = d_last;
                own_addr  = d_addr;
                own_wdata = d_wdata;
                other_req = h_req;
            end
            default: ;
        endcase
    end

    // In IDLE own_req is 0, so nothing issues while arbitrating.
    assign mem_en    = own_req;
    assign mem_we    = own_req & own_we;
    assign mem_addr  = own_req ? own_addr : '0;
    assign mem_wdata = own_req ? own_wdata : '0;

    // Forced release fires only on the MAX_HOLD-th access with a waiter;
    // without a waiter hold_cnt parks at HOLD_TOP and the tenure continues.
    assign release_now = (state != IDLE) &&
                         (!own_req || own_last || (hold_cnt == HOLD_TOP && other_req));

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values; rst_n is sampled only at the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_last  <= 1'b1;           // host wins the first tie
            hold_cnt <= '0;
            h_tag    <= 1'b0;
            d_tag    <= 1'b0;
            h_hold   <= '0;
            d_hold   <= '0;
        end else begin
            h_tag <= (state == OWN_H) && h_req && !h_we;
            d_tag <= (state == OWN_D) && d_req && !d_we;
            if (h_tag) h_hold <= mem_rdata;
            if (d_tag) d_hold <= mem_rdata;

            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (h_req && (!d_req || rr_last)) state <= OWN_H;
                    else if (d_req)                  state <= OWN_D;
                end
                OWN_H, OWN_D: begin
                    if (release_now) begin
                        hold_cnt <= '0;
                        rr_last  <= (state == OWN_D);
                        if (other_req) state <= (state == OWN_H) ? OWN_D : OWN_H;
                        else           state <= IDLE;
                    end else if (hold_cnt != HOLD_TOP) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign h_gnt    = (state == OWN_H);
    assign d_gnt    = (state == OWN_D);
    assign h_rvalid = h_tag;
    assign d_rvalid = d_tag;
    assign h_rdata  = h_tag ? mem_rdata : h_hold;
    assign d_rdata  = d_tag ? mem_rdata : d_hold;

endmodule

// File: tb/tb_buf_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_buf_port_arbiter
//
// Directed scenarios followed by a randomized phase. Every cycle the DUT
// outputs are compared with a behavioural model of the arbitration rules
// (owner, tenure length, round-robin winner, pending read per port).
// A stand-in buffer returns fn(addr) one cycle after a read, and random junk
// otherwise, so stale or misrouted read data is visible.
// -----------------------------------------------------------------------------
module tb_buf_port_arbiter;

    localparam int AW = 17;
    localparam int DW = 8;
    localparam int MH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          h_req = 0, h_we = 0, h_last = 0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic          d_req = 0, d_we = 0, d_last = 0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          h_gnt, h_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] h_rdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    buf_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_last(h_last),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_last(d_last),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] fn(input logic [AW-1:0] a);
        return a[7:0] ^ {a[16:13], a[11:8]} ^ 8'h3C;
    endfunction

    // Buffer stand-in: read data valid one cycle after a read strobe.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= fn(mem_addr);
        else                   mem_rdata <= DW'($urandom);
    end

    int n_pass = 0;
    int n_total = 0;
    int h_acc = 0;   // observed host accesses
    int d_acc = 0;   // observed DMA accesses

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference model: who owns the buffer (0 none, 1 host, 2 DMA), how many
    // accesses the owner has made, who gave the buffer up last, and the read
    // each port is still owed.
    int            m_owner = 0;
    int            m_last  = 2;
    int            m_cnt   = 0;
    bit            m_pend_h = 0, m_pend_d = 0;
    logic [DW-1:0] m_val_h = '0, m_val_d = '0, m_seen_h = '0, m_seen_d = '0;

    task automatic step(input logic rst,
                        input logic hr, input logic hw, input logic [AW-1:0] ha,
                        input logic [DW-1:0] hd, input logic hl,
                        input logic dr, input logic dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] dd, input logic dl);
        logic          iss, own_r, own_w, own_l, oth_r;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        @(negedge clk);
        rst_n = rst;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd; h_last = hl;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_last = dl;
        #1;
        own_r  = (m_owner == 1) ? hr : (m_owner == 2) ? dr : 1'b0;
        own_w  = (m_owner == 1) ? hw : dw;
        own_l  = (m_owner == 1) ? hl : dl;
        oth_r  = (m_owner == 1) ? dr : hr;
        iss    = own_r;
        e_addr = !iss ? '0 : (m_owner == 1) ? ha : da;
        e_wd   = !iss ? '0 : (m_owner == 1) ? hd : dd;

        chk("h_gnt", 32'(h_gnt), 32'(m_owner == 1));
        chk("d_gnt", 32'(d_gnt), 32'(m_owner == 2));
        chk("mem_en", 32'(mem_en), 32'(iss));
        chk("mem_we", 32'(mem_we), 32'(iss && own_w));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        chk("h_rvalid", 32'(h_rvalid), 32'(m_pend_h));
        chk("d_rvalid", 32'(d_rvalid), 32'(m_pend_d));
        chk("h_rdata", 32'(h_rdata), 32'(m_pend_h ? m_val_h : m_seen_h));
        chk("d_rdata", 32'(d_rdata), 32'(m_pend_d ? m_val_d : m_seen_d));
        if (mem_en && h_gnt) h_acc++;
        if (mem_en && d_gnt) d_acc++;

        if (!rst) begin
            m_owner = 0; m_last = 2; m_cnt = 0;
            m_pend_h = 0; m_pend_d = 0; m_seen_h = '0; m_seen_d = '0;
        end else begin
            if (m_pend_h) m_seen_h = m_val_h;
            if (m_pend_d) m_seen_d = m_val_d;
            m_pend_h = iss && m_owner == 1 && !hw;
            m_pend_d = iss && m_owner == 2 && !dw;
            if (m_pend_h) m_val_h = fn(ha);
            if (m_pend_d) m_val_d = fn(da);
            if (m_owner == 0) begin
                m_cnt = 0;
                if (hr && dr)  m_owner = (m_last == 2) ? 1 : 2;
                else if (hr)   m_owner = 1;
                else if (dr)   m_owner = 2;
            end else if (!iss || own_l || (m_cnt == MH - 1 && oth_r)) begin
                m_last  = m_owner;
                m_owner = oth_r ? 3 - m_owner : 0;
                m_cnt   = 0;
            end else if (m_cnt < MH - 1) begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
        step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
    endtask

    initial begin
        // Reset state.
        do_reset();
        step(1, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);

        // Simultaneous request after reset: host wins, 4-write burst, DMA next.
        do_reset();
        h_acc = 0;
        step(1, 1, 1, 17'h100, 8'h00, 0, 1, 1, 17'h200, 8'hAA, 0);
        chk("tie_h_gnt", 32'(h_gnt), 32'd1);
        for (int i = 0; i < 4; i++)
            step(1, 1, 1, 17'h100 + AW'(i), DW'(i + 1), logic'(i == 3), 1, 1, 17'h200, 8'hAA, 0);
        chk("burst4_d_gnt", 32'(d_gnt), 32'd1);
        chk("burst4_h_acc", 32'(h_acc), 32'd4);

        // DMA never sends last while the host waits: forced release after MH.
        do_reset();
        step(1, 0, 0, '0, '0, 0, 1, 1, 17'h300, 8'h11, 0);
        d_acc = 0;
        for (int i = 0; i < 40 && !h_gnt; i++)
            step(1, 1, 0, 17'h40, 8'h00, 0, 1, 1, 17'h300 + AW'(i), DW'(i), 0);
        chk("force_h_gnt", 32'(h_gnt), 32'd1);
        chk("force_d_acc", 32'(d_acc), 32'(MH));

        // DMA alone for 40 accesses: no forced release.
        do_reset();
        step(1, 0, 0, '0, '0, 0, 1, 0, 17'h500, 8'h00, 0);
        d_acc = 0;
        for (int i = 0; i < 40; i++)
            step(1, 0, 0, '0, '0, 0, 1, 0, 17'h500 + AW'(i), 8'h00, logic'(i == 39));
        chk("solo_d_acc", 32'(d_acc), 32'd40);
        chk("solo_idle", 32'(d_gnt), 32'd0);

        // Host read on final cycle of tenure, DMA takes over the next cycle.
        do_reset();
        step(1, 1, 0, 17'h10, 8'h00, 0, 0, 0, '0, '0, 0);
        step(1, 1, 0, 17'h10, 8'h00, 1, 1, 1, 17'h600, 8'h77, 0);
        chk("handoff_h_rvalid", 32'(h_rvalid), 32'd1);
        chk("handoff_h_rdata", 32'(h_rdata), 32'(fn(17'h10)));
        chk("handoff_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("handoff_d_gnt", 32'(d_gnt), 32'd1);
        step(1, 0, 0, '0, '0, 0, 1, 1, 17'h601, 8'h78, 1);

        // Reset lands at the edge right after a DMA read issues.
        do_reset();
        step(1, 0, 0, '0, '0, 0, 1, 0, 17'h20, 8'h00, 0);
        step(0, 0, 0, '0, '0, 0, 1, 0, 17'h20, 8'h00, 0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_d_rdata", 32'(d_rdata), 32'd0);
        step(1, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);

        // Host abandons a 5-access burst after 2, DMA waiting.
        do_reset();
        h_acc = 0;
        step(1, 1, 0, 17'h700, 8'h00, 0, 1, 0, 17'h800, 8'h00, 0);
        step(1, 1, 0, 17'h700, 8'h00, 0, 1, 0, 17'h800, 8'h00, 0);
        step(1, 1, 1, 17'h701, 8'h55, 0, 1, 0, 17'h800, 8'h00, 0);
        step(1, 0, 0, 17'h702, 8'h00, 0, 1, 0, 17'h800, 8'h00, 0);
        chk("abandon_d_gnt", 32'(d_gnt), 32'd1);
        chk("abandon_h_acc", 32'(h_acc), 32'd2);

        // Randomized traffic: busy requesters, rare last, very rare reset.
        for (int i = 0; i < 3000; i++) begin
            step(logic'($urandom_range(0, 299) != 0),
                 logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                 AW'($urandom), DW'($urandom), logic'($urandom_range(0, 7) == 0),
                 logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                 AW'($urandom), DW'($urandom), logic'($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/buf_port_arbiter.md
BUF_PORT_ARBITER -- requirements
Module: buf_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be, one per line:
  ADDR_W, 17, buffer address width
  DATA_W, 8, buffer data width
  MAX_HOLD, 16, maximum accesses per tenure while the other port waits
REQ-002 Ports (name direction width meaning) SHALL be, one per line:
  clk  in  1  clock
  rst_n  in  1  reset, synchronous, active-low
  h_req  in  1  host (AXI decoder) requests access this cycle
  h_we  in  1  host write (1) / read (0)
  h_addr  in  ADDR_W  host address
  h_wdata  in  DATA_W  host write data
  h_last  in  1  final access of host burst
  h_gnt  out  1  host owns buffer port
  h_rvalid  out  1  host read data valid
  h_rdata  out  DATA_W  host read data
  d_req, d_we, d_addr, d_wdata, d_last  in  1/1/ADDR_W/DATA_W/1  DMA equivalents
  d_gnt, d_rvalid, d_rdata  out  1/1/DATA_W  DMA equivalents
  mem_en  out  1  buffer access strobe
  mem_we  out  1  buffer write enable
  mem_addr  out  ADDR_W  buffer address
  mem_wdata  out  DATA_W  buffer write data
  mem_rdata  in  DATA_W  buffer read data, valid 1 cycle after mem_en & !mem_we

Function
REQ-003 State machine SHALL have states IDLE, OWN_H, OWN_D; h_gnt = (state==OWN_H), d_gnt = (state==OWN_D), both registered-state decodes.
REQ-004 An access SHALL issue in a cycle iff owner's req=1; mem_en=1 then, mem_we/addr/wdata driven from owner; otherwise mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
REQ-005 IDLE: single requester -> OWN_of_requester next cycle; both -> port not granted last (rr_last flag); none -> stay IDLE; arbitration latency 1 cycle, no access issues in IDLE.
REQ-006 Tenure release SHALL occur on: issued access with last=1; owner req=0; or forced release (REQ-008).
REQ-007 On release, next state SHALL be OWN_other if other req=1 that cycle, else IDLE; rr_last SHALL update to the releasing port.
REQ-008 hold_cnt SHALL count issued accesses in current tenure (clear on tenure entry); when an access issues with hold_cnt==MAX_HOLD-1 and other req=1, release SHALL be forced after that access; without waiting requester, hold_cnt SHALL saturate at MAX_HOLD-1 and no forced release occurs.
REQ-009 Read return: for each issued read, the issuing port's rvalid SHALL assert exactly 1 cycle later with rdata=mem_rdata; tag registered at issue, so ownership change does not misroute data.
REQ-010 rdata of a port SHALL hold its last value when rvalid=0; writes generate no rvalid.
REQ-011 Never both gnt=1; never mem_en without owner req.
REQ-012 Requester drops req mid-burst without last: that cycle issues nothing, release per REQ-006/007.

Reset
REQ-013 rst_n=0 at a clk edge SHALL force state=IDLE, rr_last=DMA (host wins first tie), hold_cnt=0, read tag cleared, h_gnt=d_gnt=0, h_rvalid=d_rvalid=0, h_rdata=d_rdata=0.
REQ-014 Reset mid-burst or with read outstanding SHALL drop the outstanding read (no rvalid after reset) and the next grant SHALL follow REQ-005.

Verification
REQ-015 Reset, h_req=d_req=1 simultaneously -> cycle 1 h_gnt=1; host bursts 4 writes (last on 4th) -> cycle 5 d_gnt=1, mem_en count 4 with host addresses.
REQ-016 DMA holds req, never last, host requests continuously, MAX_HOLD=16 -> exactly 16 DMA accesses then h_gnt=1 next cycle.
REQ-017 DMA alone, 40-access burst, host idle -> no forced release, 40 consecutive mem_en cycles, d_gnt continuous.
REQ-018 Host read addr 0x10 issued on final cycle of tenure, DMA granted next -> h_rvalid=1 one cycle after issue with mem_rdata, d_rvalid=0.
REQ-019 rst_n=0 one cycle after DMA read issue -> d_rvalid stays 0, state IDLE, all outputs zero.
REQ-020 Host req deasserts after 2 of planned 5 accesses, DMA waiting -> d_gnt=1 next cycle, host mem_en count 2.
